// File: rtl/eight_comparator_tcs.sv
// Registered 8-bit unsigned magnitude comparator (equal / greater-than flags).
// Latency: one cycle from a/b sampled at a rising edge to e/g.
// Backpressure: none; accepts a new operand pair every cycle, no handshake.
//
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset, clears e and g
//   a, b - unsigned operands, declared [0:7] so index 0 is the MSB
//   e    - registered flag, a == b
//   g    - registered flag, a >  b
//
// Structure: eight bit slices produce per-bit eq/gt terms, and a chain of
// cascade cells walks them from the MSB (index 0) down to the LSB (index 7).
// The cascade output is captured in a two-bit result register.

// ---------------------------------------------------------------------------
// Per-bit compare slice.
// Purely combinational, zero latency.
// No flow control.
// ---------------------------------------------------------------------------
module eight_comparator_tcs_slice (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt
);
    // eq: bits match; gt: this bit alone says a > b.
    assign eq = ~(a ^ b);
    assign gt = a & ~b;
endmodule

// ---------------------------------------------------------------------------
// One stage of the MSB-first cascade.
// Purely combinational, zero latency.
// No flow control.
// ---------------------------------------------------------------------------
module eight_comparator_tcs_cell (
    input  logic e_in,
    input  logic g_in,
    input  logic eq,
    input  logic gt,
    output logic e_out,
    output logic g_out
);
    // A bit may only decide "greater" while every higher bit still matches;
    // once a higher bit has decided, e_in is 0 and this stage cannot change g.
    assign e_out = e_in & eq;
    assign g_out = g_in | (e_in & gt);
endmodule

// ---------------------------------------------------------------------------
// Top level.
// Latency one cycle; registered outputs.
// No backpressure; a new compare every cycle.
// ---------------------------------------------------------------------------
module eight_comparator_tcs (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] a,
    input  logic [0:7] b,
    output logic       e,
    output logic       g
);
    logic [0:7] eq_bit;
    logic [0:7] gt_bit;

    // Cascade chain: entry 0 is the seed, entry i+1 is the result after bit i.
    logic [0:8] e_chain;
    logic [0:8] g_chain;

    logic eq_c;
    logic gt_c;

    // Seeding with "all equal so far, not yet greater" makes the first cell
    // yield E_0 = eq_0 and G_0 = gt_0 without a special-cased bit 0.
    assign e_chain[0] = 1'b1;
    assign g_chain[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        eight_comparator_tcs_slice u_slice (
            .a  (a[i]),
            .b  (b[i]),
            .eq (eq_bit[i]),
            .gt (gt_bit[i])
        );

        eight_comparator_tcs_cell u_cell (
            .e_in  (e_chain[i]),
            .g_in  (g_chain[i]),
            .eq    (eq_bit[i]),
            .gt    (gt_bit[i]),
            .e_out (e_chain[i+1]),
            .g_out (g_chain[i+1])
        );
    end

    // Final cascade taps; this a/b -> cascade -> flop path is the critical one.
    assign eq_c = e_chain[8];
    assign gt_c = g_chain[8];

    // e and g are mutually exclusive by construction: g can only set through a
    // bit where eq is 0, which forces E low for every later stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            e <= 1'b0;
            g <= 1'b0;
        end else begin
            e <= eq_c;
            g <= gt_c;
        end
    end

endmodule

// File: tb/tb_eight_comparator_tcs.sv
// Testbench for eight_comparator_tcs: directed cases, randomized stream with
// occasional resets, and an exhaustive sweep against a value-level model.
module tb_eight_comparator_tcs;

    logic       clk;
    logic       rst;
    logic [0:7] a;
    logic [0:7] b;
    logic       e;
    logic       g;

    int n_cmp;
    int n_bad;

    eight_comparator_tcs dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .e   (e),
        .g   (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic on the operand values.
    function automatic logic [1:0] ref_eg(input int av, input int bv, input bit r);
        if (r) return 2'b00;
        return {(av == bv) ? 1'b1 : 1'b0, (av > bv) ? 1'b1 : 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got e/g=%b required e/g=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one operand pair (and rst) away from the active edge, then check
    // the registered result just after the edge that samples it.
    task automatic step(input int av, input int bv, input bit r, input string tag);
        logic [7:0] av8;
        logic [7:0] bv8;
        av8 = av[7:0];
        bv8 = bv[7:0];
        @(negedge clk);
        a   = av8;
        b   = bv8;
        rst = r;
        @(posedge clk);
        #1;
        chk(tag, {e, g}, ref_eg(av & 255, bv & 255, r));
        chk({tag, "_excl"}, {1'b0, e & g}, 2'b00);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;

        // Reset and equal zeros.
        step(8'b00000000, 8'b00000000, 1'b1, "reset");
        step(8'b00000000, 8'b00000000, 1'b0, "zeros_eq");

        // MSB decides.
        step(8'b10000000, 8'b00000000, 1'b0, "msb_gt");
        step(8'b10000000, 8'b10000000, 1'b0, "msb_eq");
        step(8'b00000000, 8'b10000000, 1'b0, "msb_lt");

        // Lower bits cannot override the MSB.
        step(8'b01110000, 8'b10000000, 1'b0, "low_no_override");
        step(8'b11110000, 8'b10110000, 1'b0, "bit1_gt");

        // Mid-bit and LSB decisions.
        step(8'b11111111, 8'b10111111, 1'b0, "mid_gt");
        step(8'b11110111, 8'b10111111, 1'b0, "bit1_before_bit4");
        step(8'b11111111, 8'b11111111, 1'b0, "ones_eq");
        step(8'b11111110, 8'b11111111, 1'b0, "lsb_lt");

        // Reset for one cycle while a > b, then recovery.
        step(8'd200, 8'd100, 1'b0, "pre_rst_gt");
        step(8'd200, 8'd100, 1'b1, "mid_rst");
        step(8'd200, 8'd100, 1'b0, "post_rst_gt");

        // Randomized stream: operands change every cycle, sparse resets,
        // and a bias toward near-equal pairs so low bits get to decide.
        for (int i = 0; i < 2000; i++) begin
            int av;
            int bv;
            bit r;
            av = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                bv = av ^ (1 << $urandom_range(0, 7));
            else if ($urandom_range(0, 7) == 0)
                bv = av;
            else
                bv = int'($urandom_range(0, 255));
            r = ($urandom_range(0, 31) == 0);
            step(av, bv, r, "rand");
        end

        // Exhaustive sweep.
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                step(ai, bi, 1'b0, "sweep");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eight_comparator_tcs.md
# eight_comparator_tcs

Registered 8-bit unsigned magnitude comparator. It reports whether operand `a` equals operand `b` and whether `a` is strictly greater than `b`. The compare core is a bit-sliced cascade that runs from the most significant bit downwards, in switch/gate style, and it feeds an output register. The block is a leaf used wherever a registered equal/greater flag pair is needed.

## Interface
- Parameters: none. Width is fixed at 8 bits.
- `clk`  input  1  Single clock. All state updates on the rising edge.
- `rst`  input  1  Synchronous, active-high reset.
- `a`  input  [0:7]  Operand A, unsigned. Bit 0 is the MSB and bit 7 is the LSB.
- `b`  input  [0:7]  Operand B, unsigned. Same bit ordering as `a`.
- `e`  output  1  Registered flag, 1 when a == b.
- `g`  output  1  Registered flag, 1 when a > b (unsigned).
- Port declaration order: `clk`, `rst`, `a`, `b`, `e`, `g`.

## Operation
- Per-bit slice i, for i = 0..7:
  - eq_i = ~(a[i] ^ b[i])
  - gt_i = a[i] & ~b[i]
- MSB-first cascade, starting at bit 0:
  - E_0 = eq_0 and G_0 = gt_0.
  - E_i = E_{i-1} & eq_i.
  - G_i = G_{i-1} | (E_{i-1} & gt_i).
- Combinational results: eq_c = E_7, gt_c = G_7.
- The first differing bit from the MSB alone decides gt. Lower bits never override a decided higher bit.
- Less-than is implied by e=0 and g=0. It is not a port.
- Invariant: e and g are never both 1, in any cycle, including the reset cycle.
- Inputs are plain unsigned binary. There is no sign handling and no X-propagation masking requirement.

## Timing
- On each rising `clk` edge:
  - If `rst`=1: e←0, g←0.
  - Otherwise: e←eq_c and g←gt_c, computed from a and b as sampled at that edge.
- Reset values: e=0, g=0.
- Latency: one cycle. Outputs reflect the inputs sampled at the previous rising edge and hold until the next edge.
- Throughput: one compare per cycle. There is no handshake and no valid signal, and inputs may change every cycle.
- Reset asserted mid-stream: outputs clear at the first edge with rst=1 and stay 0 while rst=1. The first edge with rst=0 loads the compare of the inputs present at that edge.
- Reset has priority over any simultaneous input change.
- The combinational path a/b → register must close in one clock period. The 8-stage cascade is the critical path.

## Test plan
- Reset and equal zeros:
  - Hold rst=1 with a=00000000, b=00000000. Required: e=0, g=0 after the edge.
  - Release rst. Required: e=1, g=0 one edge later.
- MSB decides:
  - a=10000000, b=00000000. Required: e=0, g=1.
  - Then b=10000000. Required: e=1, g=0.
  - Then a=00000000. Required: e=0, g=0.
- Lower bits cannot override the MSB:
  - a=01110000, b=10000000. Required: e=0, g=0.
  - a=11110000, b=10110000. Required: e=0, g=1.
- Mid-bit and LSB decisions:
  - a=11111111, b=10111111. Required: g=1, e=0.
  - a=11110111, b=10111111. Required: g=1, e=0, because bit 1 decides before bit 4.
  - a=11111111, b=11111111. Required: e=1, g=0.
  - a=11111110, b=11111111. Required: e=0, g=0.
- Latency and reset mid-operation:
  - Change operands every cycle. Required: each output pair matches the operands of the prior edge.
  - Assert rst for one cycle while a>b. Required: g drops to 0 for that cycle and returns to 1 on the following edge.
- Exhaustive sweep: all 65 536 (a, b) pairs against a reference model. Required: exact match, one cycle later, with e&g never 1.
